// File: rtl/alu_rr_arbiter_pkg.sv
// Shared opcode and FSM state definitions for the round-robin ALU arbiter.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_INV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_DEF = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_rr_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid request after last_grant, wrapping.
module rr_picker
  import alu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any_valid
);

  always_comb begin : pick
    int          sum;
    logic [ID_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    sum       = 0;
    idx       = '0;
    // Offset 1 first so the previous winner has the lowest priority.
    for (int k = 1; k <= N_REQ; k++) begin
      sum = int'(last_grant) + k;
      idx = ID_W'(sum % N_REQ);
      if (!any_valid && req[idx]) begin
        any_valid  = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin sharing of one external combinational ALU among N_REQ requesters,
// with registered operand drive and a single tagged, back-pressurable response.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [8*N_REQ-1:0] req_a,
  input  logic [8*N_REQ-1:0] req_b,
  input  logic [3*N_REQ-1:0] req_op,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [2:0]         alu_op,
  input  logic [15:0]        alu_r,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [15:0]        rsp_r,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  state_t            state;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   tag;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              any_valid;

  logic [7:0] a_arr  [N_REQ];
  logic [7:0] b_arr  [N_REQ];
  logic [2:0] op_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i]  = req_a[8*i +: 8];
    assign b_arr[i]  = req_b[8*i +: 8];
    assign op_arr[i] = req_op[3*i +: 3];
  end

  rr_picker #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_picker (
    .req       (req_valid),
    .last_grant(last_grant),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  // Ready is gated by rst_n so nothing looks accepted while reset is held.
  assign req_ready = (state == ST_IDLE && rst_n) ? grant : '0;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= ID_W'(N_REQ - 1);
      tag        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_r      <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            alu_a      <= a_arr[grant_idx];
            alu_b      <= b_arr[grant_idx];
            alu_op     <= op_arr[grant_idx];
            tag        <= grant_idx;
            last_grant <= grant_idx;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_r     <= alu_r;
          rsp_id    <= tag;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a behavioural ALU model on the alu_* bus.
module tb_alu_rr_arbiter;
  import alu_pkg::*;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [11:0] req_op;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_r, rsp_r;
  logic        rsp_valid, rsp_ready, busy;
  logic [1:0]  rsp_id;
  logic [1:0]  op_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      OP_ADD:  alu_r = {8'h00, alu_a} + {8'h00, alu_b};
      OP_SUB:  alu_r = {8'h00, alu_a} - {8'h00, alu_b};
      OP_MUL:  alu_r = {8'h00, alu_a} * {8'h00, alu_b};
      OP_INV:  alu_r = {8'h00, ~alu_a};
      OP_AND:  alu_r = {8'h00, alu_a & alu_b};
      OP_OR:   alu_r = {8'h00, alu_a | alu_b};
      OP_XOR:  alu_r = {8'h00, alu_a ^ alu_b};
      default: alu_r = 16'h0000;
    endcase
  end

  alu_rr_arbiter #(.N_REQ(N), .ID_W(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r),
    .busy(busy), .op_count(op_count)
  );

  task automatic drive_cmd(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
    req_op[3*i +: 3] = op;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    n_checks++; if ({alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_r, op_count, busy, req_ready} !== '0)
      $display("FAIL reset_outputs got a=%0d b=%0d op=%0d v=%0d id=%0d r=%0d cnt=%0d busy=%0d rdy=%b exp all 0",
               alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_r, op_count, busy, req_ready); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_idle_ready got %b exp 0000", req_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got %0d exp 0", busy); else n_pass++;
  endtask

  task automatic test_single_add();
    do_reset();
    drive_cmd(0, 8'd8, 8'd5, OP_ADD);
    req_valid = 4'b0001; #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL add_ready got %b exp 0001", req_ready); else n_pass++;
    @(negedge clk); req_valid = '0; #1;
    n_checks++; if (alu_a !== 8'd8 || alu_b !== 8'd5) $display("FAIL add_operands got a=%0d b=%0d exp a=8 b=5", alu_a, alu_b); else n_pass++;
    n_checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL add_exec got busy=%0d v=%0d exp busy=1 v=0", busy, rsp_valid); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_r !== 16'd13 || rsp_id !== 2'd0)
      $display("FAIL add_rsp got v=%0d r=%0d id=%0d exp v=1 r=13 id=0", rsp_valid, rsp_r, rsp_id); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (op_count !== 2'd1 || rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL add_done got cnt=%0d v=%0d busy=%0d exp cnt=1 v=0 busy=0", op_count, rsp_valid, busy); else n_pass++;
  endtask

  task automatic test_contention();
    int exp_g [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) drive_cmd(i, 8'(i), 8'd10, OP_ADD);
    req_valid = 4'b1111; #1;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (req_ready !== 4'(1 << exp_g[k])) $display("FAIL rr_grant%0d got %b exp %b", k, req_ready, 4'(1 << exp_g[k])); else n_pass++;
      @(negedge clk); @(negedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_r !== 16'(10 + exp_g[k]) || rsp_id !== 2'(exp_g[k]))
        $display("FAIL rr_rsp%0d got v=%0d r=%0d id=%0d exp v=1 r=%0d id=%0d", k, rsp_valid, rsp_r, rsp_id, 10 + exp_g[k], exp_g[k]); else n_pass++;
      @(negedge clk); #1;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < N; i++) drive_cmd(i, 8'(i), 8'd10, OP_ADD);
    drive_cmd(2, 8'd255, 8'd100, OP_MUL);
    rsp_ready = 1'b0;
    req_valid = 4'b0100; #1;
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL bp_grant got %b exp 0100", req_ready); else n_pass++;
    @(negedge clk); req_valid = 4'b1011; #1;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL bp_exec_ready got %b exp 0000", req_ready); else n_pass++;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_r !== 16'h639C || rsp_id !== 2'd2 || req_ready !== 4'b0000)
        $display("FAIL bp_hold%0d got v=%0d r=%0d id=%0d rdy=%b exp v=1 r=25500 id=2 rdy=0000", h, rsp_valid, rsp_r, rsp_id, req_ready); else n_pass++;
    end
    @(negedge clk); rsp_ready = 1'b1; #1;
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_before_hs got v=%0d exp 1", rsp_valid); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0 || op_count !== 2'd1 || busy !== 1'b0 || rsp_r !== 16'h639C || rsp_id !== 2'd2)
      $display("FAIL bp_after_hs got v=%0d cnt=%0d busy=%0d r=%0d id=%0d exp v=0 cnt=1 busy=0 r=25500 id=2", rsp_valid, op_count, busy, rsp_r, rsp_id); else n_pass++;
    n_checks++; if (req_ready !== 4'b1000) $display("FAIL bp_next_grant got %b exp 1000", req_ready); else n_pass++;
    req_valid = '0;
  endtask

  task automatic test_passthrough();
    int          idx [3] = '{1, 3, 0};
    logic [7:0]  ta  [3] = '{8'd255, 8'd8, 8'd255};
    logic [7:0]  tb  [3] = '{8'd100, 8'd5, 8'd100};
    logic [2:0]  top [3] = '{OP_SUB, OP_XOR, OP_AND};
    logic [15:0] tr  [3] = '{16'd155, 16'd13, 16'd100};
    do_reset();
    for (int t = 0; t < 3; t++) begin
      drive_cmd(idx[t], ta[t], tb[t], top[t]);
      req_valid = 4'(1 << idx[t]); #1;
      n_checks++; if (req_ready !== 4'(1 << idx[t])) $display("FAIL pt_ready%0d got %b exp %b", t, req_ready, 4'(1 << idx[t])); else n_pass++;
      @(negedge clk); req_valid = '0; #1;
      n_checks++; if (alu_op !== top[t]) $display("FAIL pt_op%0d got %0d exp %0d", t, alu_op, top[t]); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (rsp_r !== tr[t] || rsp_id !== 2'(idx[t]))
        $display("FAIL pt_rsp%0d got r=%0d id=%0d exp r=%0d id=%0d", t, rsp_r, rsp_id, tr[t], idx[t]); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    for (int i = 0; i < N; i++) drive_cmd(i, 8'(i), 8'd10, OP_ADD);
    req_valid = 4'b0010; #1;
    @(negedge clk); req_valid = '0; #1;
    n_checks++; if (busy !== 1'b1 || alu_b !== 8'd10) $display("FAIL rst_mid_exec got busy=%0d b=%0d exp busy=1 b=10", busy, alu_b); else n_pass++;
    rst_n = 1'b0; #1;
    n_checks++; if ({alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_r, op_count, busy, req_ready} !== '0)
      $display("FAIL rst_mid_clear got a=%0d b=%0d op=%0d v=%0d id=%0d r=%0d cnt=%0d busy=%0d rdy=%b exp all 0",
               alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_r, op_count, busy, req_ready); else n_pass++;
    req_valid = 4'b1111;
    @(negedge clk); #1;
    n_checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) $display("FAIL rst_mid_held got rdy=%b v=%0d exp rdy=0000 v=0", req_ready, rsp_valid); else n_pass++;
    rst_n = 1'b1; #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL rst_mid_first_grant got %b exp 0001", req_ready); else n_pass++;
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_r !== 16'd10 || op_count !== 2'd0)
      $display("FAIL rst_mid_rsp got v=%0d id=%0d r=%0d cnt=%0d exp v=1 id=0 r=10 cnt=0", rsp_valid, rsp_id, rsp_r, op_count); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_counter_wrap();
    logic [1:0] exp_cnt [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    do_reset();
    drive_cmd(0, 8'd1, 8'd2, OP_ADD);
    req_valid = 4'b0001; #1;
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (busy !== 1'b0) $display("FAIL wrap_idle%0d busy got %0d exp 0", k, busy); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (busy !== 1'b1) $display("FAIL wrap_exec%0d busy got %0d exp 1", k, busy); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (busy !== 1'b1 || rsp_valid !== 1'b1) $display("FAIL wrap_resp%0d got busy=%0d v=%0d exp 1 1", k, busy, rsp_valid); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (op_count !== exp_cnt[k]) $display("FAIL wrap_cnt%0d got %0d exp %0d", k, op_count, exp_cnt[k]); else n_pass++;
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_contention();
    test_backpressure();
    test_passthrough();
    test_reset_mid_op();
    test_counter_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
